mem_port_arbiter: RTL and testbench

- Shares one unified, variable-latency memory port between the instruction-fetch requester and the load/store requester of the RV32I core.
- Sits between the core (PC/IMEM path and data-memory path) and a single memory.
- Uses a req/ack handshake on both sides, a grant FSM, operand capture and a wait-timeout watchdog.
- Exposes busy so the core can freeze its PC while an access is outstanding.

---
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and load/store.
// Grant is combinational in the IDLE cycle; mem_req follows one cycle later; x_valid one cycle after mem_ack/timeout.
// Build option MEM_ARB_RR_EN: round-robin tie-break instead of fixed data-over-fetch priority.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic       if_pend, d_pend, pick_d, pick_if;
  logic       in_busy, done, timeout;

  // A requester still holds req during its own valid pulse; that cycle must not re-grant it.
  assign if_pend = if_req & ~if_valid;
  assign d_pend  = d_req & ~d_valid;

`ifdef MEM_ARB_RR_EN
  logic last_d;  // 1 = most recent grant went to data

  assign pick_d = d_pend & (~if_pend | ~last_d);

  // Remember which side won the most recent grant for the tie-break.
  always_ff @(posedge clk) begin
    if (rst)        last_d <= 1'b0;
    else if (d_gnt) last_d <= 1'b1;
    else if (if_gnt) last_d <= 1'b0;
  end
`else
  assign pick_d = d_pend;
`endif

  assign pick_if = if_pend & ~pick_d;

  // mem_ack is only meaningful while an access is outstanding.
  assign in_busy = (state != IDLE);
  assign done    = in_busy & mem_ack;
  assign timeout = in_busy & ~mem_ack & (wait_cnt == WAIT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and grant decode; grants are suppressed while reset is asserted.
  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && pick_d) begin
          d_gnt     = 1'b1;
          state_nxt = BUSY_D;
        end else if (!rst && pick_if) begin
          if_gnt    = 1'b1;
          state_nxt = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (done || timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, wait counter, completion pulses and returned data.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wait_cnt  <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      err       <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      busy     <= (state_nxt != IDLE);
      mem_req  <= (state_nxt != IDLE);
      if_valid <= (state == BUSY_IF) & (done | timeout);
      d_valid  <= (state == BUSY_D) & (done | timeout);
      err      <= timeout;

      if (d_gnt) begin
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        wait_cnt  <= '0;
      end else if (if_gnt) begin
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        wait_cnt  <= '0;
      end else if (in_busy && !mem_ack) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      // Stores and aborted accesses return zero data.
      if (state == BUSY_IF && done)         if_rdata <= mem_rdata;
      else if (state == BUSY_IF && timeout) if_rdata <= '0;
      if (state == BUSY_D && done)          d_rdata  <= mem_we ? '0 : mem_rdata;
      else if (state == BUSY_D && timeout)  d_rdata  <= '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter built with MAX_WAIT=4.
// Single-access vectors run from a table; ties, reset and stray-ack cases are hand sequences.
// Inputs change 1 time unit after the rising edge and outputs are checked 1 unit later.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_valid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_valid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_req, mem_we, mem_ack, busy, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  string tag = "";
  logic [DW-1:0] exp_if_rdata, exp_d_rdata;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          k;       // BUSY cycle index where ack arrives (or the timeout cycle)
    logic        ack;     // 0 = never acked, access must time out
    logic [31:0] rdata;   // value driven on mem_rdata
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL [%s] %s: got 0x%08h, expected 0x%08h", tag, nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL [%s] %s: got %b, expected %b", tag, nm, act, exp);
    end
  endtask

  // One complete access starting in an IDLE cycle; leaves the DUT in the cycle of x_valid.
  task automatic run_vec(input vec_t v);
    cyc();
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    chk1("gnt", v.is_d ? d_gnt : if_gnt, 1'b1);
    chk1("other_gnt", v.is_d ? if_gnt : d_gnt, 1'b0);
    chk1("busy_at_grant", busy, 1'b0);
    for (int i = 1; i <= v.k; i++) begin
      cyc();
      mem_ack   = v.ack && (i == v.k);
      mem_rdata = v.rdata;
      #1;
      chk1("mem_req_busy", mem_req, 1'b1);
      chk1("valid_early", v.is_d ? d_valid : if_valid, 1'b0);
      if (i == 1) begin
        chk("mem_addr", mem_addr, v.addr);
        chk1("mem_we", mem_we, v.is_d & v.we);
        chk("mem_wdata", mem_wdata, v.is_d ? v.wdata : 32'h0);
        chk1("busy", busy, 1'b1);
        chk1("gnt_in_busy", v.is_d ? d_gnt : if_gnt, 1'b0);
      end
    end
    cyc();
    mem_ack = 1'b0;
    #1;
    if (v.is_d) exp_d_rdata = v.exp_rdata;
    else        exp_if_rdata = v.exp_rdata;
    chk1("valid", v.is_d ? d_valid : if_valid, 1'b1);
    chk1("err", err, v.exp_err);
    chk("if_rdata", if_rdata, exp_if_rdata);
    chk("d_rdata", d_rdata, exp_d_rdata);
    chk1("busy_done", busy, 1'b0);
    chk1("mem_req_done", mem_req, 1'b0);
    chk1("no_regrant", v.is_d ? d_gnt : if_gnt, 1'b0);
    if_req = 1'b0;
    d_req  = 1'b0;
  endtask

  initial begin
    logic exp_d_wins[3];

    //              is_d we  addr          wdata         k  ack rdata         exp_rdata     err
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         2, 1'b1, 32'h0050_0093, 32'h0050_0093, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1, 1'b1, 32'h1234_5678, 32'h0,         1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0200, 32'h5555_0000, 3, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0204, 32'h0,         4, 1'b0, 32'hFFFF_FFFF, 32'h0,         1'b1};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         4, 1'b1, 32'h0000_0013, 32'h0000_0013, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,         4, 1'b0, 32'h7777_7777, 32'h0,         1'b1};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,         1, 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0};

    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b1; d_we = 1'b0;
    d_addr = 32'h8; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    exp_if_rdata = '0; exp_d_rdata = '0;

    tag = "reset";
    cyc(); cyc();
    chk1("d_gnt", d_gnt, 1'b0);
    chk1("if_gnt", if_gnt, 1'b0);
    chk1("busy", busy, 1'b0);
    chk1("mem_req", mem_req, 1'b0);
    chk1("mem_we", mem_we, 1'b0);
    chk("mem_addr", mem_addr, 32'h0);
    chk("mem_wdata", mem_wdata, 32'h0);
    chk1("if_valid", if_valid, 1'b0);
    chk1("d_valid", d_valid, 1'b0);
    chk1("err", err, 1'b0);
    chk("if_rdata", if_rdata, 32'h0);
    chk("d_rdata", d_rdata, 32'h0);
    d_req = 1'b0;
    rst = 1'b0;

    for (int n = 0; n < 7; n++) begin
      tag = $sformatf("vec%0d", n);
      run_vec(vecs[n]);
    end

    tag = "stray_ack";
    cyc();
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk1("busy", busy, 1'b0);
      chk1("mem_req", mem_req, 1'b0);
      chk1("if_valid", if_valid, 1'b0);
      chk1("d_valid", d_valid, 1'b0);
      chk("d_rdata", d_rdata, exp_d_rdata);
    end
    mem_ack = 1'b0;

    tag = "reset_mid_op";
    cyc();
    if_req = 1'b1; if_addr = 32'h0000_0048;
    #1;
    chk1("if_gnt", if_gnt, 1'b1);
    cyc();
    rst = 1'b1; if_req = 1'b0;
    #1;
    chk1("mem_req_before", mem_req, 1'b1);
    cyc();
    chk1("mem_req", mem_req, 1'b0);
    chk1("busy", busy, 1'b0);
    chk1("if_valid", if_valid, 1'b0);
    chk("if_rdata", if_rdata, 32'h0);
    rst = 1'b0;
    exp_if_rdata = '0; exp_d_rdata = '0;
    cyc();
    chk1("if_valid_after", if_valid, 1'b0);
    chk1("busy_after", busy, 1'b0);
    tag = "fetch_after_reset";
    run_vec('{1'b0, 1'b0, 32'h0, 32'h0, 1, 1'b1, 32'h0000_0013, 32'h0000_0013, 1'b0});

    tag = "tie_pending";
    cyc();
    if_req = 1'b1; if_addr = 32'h0000_0080;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0400; d_wdata = '0;
    #1;
    chk1("d_gnt", d_gnt, 1'b1);
    chk1("if_gnt", if_gnt, 1'b0);
    cyc();
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    #1;
    chk("mem_addr_d", mem_addr, 32'h0000_0400);
    chk1("if_gnt_busy", if_gnt, 1'b0);
    cyc();
    mem_ack = 1'b0;
    #1;
    chk1("d_valid", d_valid, 1'b1);
    chk("d_rdata", d_rdata, 32'h1111_2222);
    chk1("if_gnt_late", if_gnt, 1'b1);
    chk1("d_gnt_masked", d_gnt, 1'b0);
    d_req = 1'b0;
    cyc();
    mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
    #1;
    chk("mem_addr_if", mem_addr, 32'h0000_0080);
    chk1("mem_we_if", mem_we, 1'b0);
    cyc();
    mem_ack = 1'b0;
    #1;
    chk1("if_valid", if_valid, 1'b1);
    chk("if_rdata", if_rdata, 32'h3333_4444);
    chk1("if_gnt_masked", if_gnt, 1'b0);
    if_req = 1'b0;
    exp_if_rdata = 32'h3333_4444;
    exp_d_rdata  = 32'h1111_2222;

    // Fresh simultaneous requests; both withdraw in the ack cycle so each round is a new tie.
`ifdef MEM_ARB_RR_EN
    exp_d_wins = '{1'b1, 1'b0, 1'b1};
`else
    exp_d_wins = '{1'b1, 1'b1, 1'b1};
`endif
    for (int t = 0; t < 3; t++) begin
      tag = $sformatf("tie%0d", t);
      cyc();
      if_req = 1'b1; if_addr = 32'h0000_0C00 + 32'(t);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0D00 + 32'(t);
      #1;
      chk1("d_gnt", d_gnt, exp_d_wins[t]);
      chk1("if_gnt", if_gnt, ~exp_d_wins[t]);
      cyc();
      mem_ack = 1'b1; mem_rdata = 32'h0000_0100 + 32'(t);
      if_req = 1'b0; d_req = 1'b0;
      #1;
      chk("mem_addr", mem_addr, exp_d_wins[t] ? 32'h0000_0D00 + 32'(t) : 32'h0000_0C00 + 32'(t));
      cyc();
      mem_ack = 1'b0;
      #1;
      if (exp_d_wins[t]) exp_d_rdata = 32'h0000_0100 + 32'(t);
      else               exp_if_rdata = 32'h0000_0100 + 32'(t);
      chk1("d_valid", d_valid, exp_d_wins[t]);
      chk1("if_valid", if_valid, ~exp_d_wins[t]);
      chk("d_rdata", d_rdata, exp_d_rdata);
      chk("if_rdata", if_rdata, exp_if_rdata);
    end

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
